// File: rtl/pzvip_spi_master_engine.sv
// SPI master engine: one frame per accepted command, all four CPOL/CPHA modes,
// programmable half period H = div+1, MSB/LSB-first and SS-held bursts.
//   state | meaning
//   IDLE  | SS high, command port open
//   SETUP | SS low for one H before the first SCLK edge
//   LEAD  | count H, then leading SCLK edge
//   TRAIL | count H, then trailing SCLK edge
//   HOLD  | CPHA=0 only: one H after the last edge
//   RSP   | response presented, pins frozen until handshake
//   CONT  | burst: SS held low, SCLK at CPOL, command port open
//   GAP   | SS high for one H between selections
module pzvip_spi_master_engine #(
    parameter int SS_WIDTH   = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 8,
    localparam int SLV_W  = (SS_WIDTH > 1) ? $clog2(SS_WIDTH) : 1,
    localparam int BITS_W = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [SLV_W-1:0]      i_cmd_slave,
    input  logic                  i_cmd_cpol,
    input  logic                  i_cmd_cpha,
    input  logic                  i_cmd_lsb_first,
    input  logic [DIV_WIDTH-1:0]  i_cmd_div,
    input  logic [BITS_W-1:0]     i_cmd_bits,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    input  logic                  i_cmd_last,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_sclk,
    output logic [SS_WIDTH-1:0]   o_ss_n,
    output logic                  o_mosi,
    input  logic                  i_miso,
    output logic                  o_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LEAD, S_TRAIL, S_HOLD, S_RSP, S_CONT, S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [BITS_W-1:0]     bit_idx_q, bit_idx_d, bits_q, bits_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
    logic [SLV_W-1:0]      slave_q, slave_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic                  last_q, last_d, pend_q, pend_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d;
    logic [SS_WIDTH-1:0]   ss_n_q, ss_n_d;
    logic                  rsp_valid_q, rsp_valid_d, busy_q, busy_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic                  accept, latch, start, use_q, finish;
    logic [BITS_W-1:0]     bits_c;
    logic [DATA_WIDTH-1:0] tx_align, rx_smp, st_tx;
    logic                  st_cpol, st_cpha, st_lsb;
    logic [DIV_WIDTH-1:0]  st_div;
    logic [SLV_W-1:0]      st_slave;

    // Out-of-range indices match no line, so the frame runs unselected.
    function automatic logic [SS_WIDTH-1:0] ss_decode(input logic [SLV_W-1:0] s);
        logic [SS_WIDTH-1:0] r;
        r = '1;
        for (int i = 0; i < SS_WIDTH; i++)
            if (32'(s) == i) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic bit_out(input logic lsb, input logic [DATA_WIDTH-1:0] v);
        return lsb ? v[0] : v[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic lsb,
                                                       input logic [DATA_WIDTH-1:0] v);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        bits_d      = bits_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        slave_d     = slave_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        lsb_d       = lsb_q;
        last_d      = last_q;
        pend_d      = pend_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        ss_n_d      = ss_n_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        cmd_ready_d = cmd_ready_q;

        accept = i_cmd_valid && cmd_ready_q;
        latch  = 1'b0;
        start  = 1'b0;
        use_q  = 1'b0;
        finish = 1'b0;

        bits_c = (i_cmd_bits == '0 || int'(i_cmd_bits) > DATA_WIDTH)
               ? BITS_W'(DATA_WIDTH) : i_cmd_bits;
        // MSB-first data is left-aligned so the first bit always sits at the top.
        tx_align = i_cmd_lsb_first ? i_cmd_data
                                   : (i_cmd_data << (DATA_WIDTH - int'(bits_c)));
        rx_smp = lsb_q ? (rx_q | (DATA_WIDTH'(i_miso) << bit_idx_q))
                       : ((rx_q << 1) | DATA_WIDTH'(i_miso));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    latch = 1'b1;
                    start = 1'b1;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_LEAD;
                    cnt_d   = div_q;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_LEAD: begin
                if (cnt_q == '0) begin
                    sclk_d  = ~sclk_q;
                    state_d = S_TRAIL;
                    cnt_d   = div_q;
                    if (!cpha_q) begin
                        rx_d = rx_smp;
                    end else begin
                        mosi_d = bit_out(lsb_q, tx_q);
                        tx_d   = shift_out(lsb_q, tx_q);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_TRAIL: begin
                if (cnt_q == '0) begin
                    sclk_d = ~sclk_q;
                    cnt_d  = div_q;
                    if (cpha_q) rx_d = rx_smp;
                    if (bit_idx_q == bits_q - BITS_W'(1)) begin
                        if (!cpha_q) state_d = S_HOLD;
                        else         finish  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BITS_W'(1);
                        state_d   = S_LEAD;
                        if (!cpha_q) begin
                            mosi_d = bit_out(lsb_q, tx_q);
                            tx_d   = shift_out(lsb_q, tx_q);
                        end
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) finish = 1'b1;
                else             cnt_d  = cnt_q - DIV_WIDTH'(1);
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (last_q) begin
                        state_d = S_GAP;
                        cnt_d   = div_q;
                    end else begin
                        state_d     = S_CONT;
                        cmd_ready_d = 1'b1;
                    end
                end
            end
            S_CONT: begin
                if (accept) begin
                    latch = 1'b1;
                    if (i_cmd_slave == slave_q && i_cmd_cpol == cpol_q) begin
                        start = 1'b1;
                    end else begin
                        // The gap is timed with the outgoing frame's divider.
                        ss_n_d      = '1;
                        state_d     = S_GAP;
                        cnt_d       = div_q;
                        pend_d      = 1'b1;
                        cmd_ready_d = 1'b0;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    if (pend_q) begin
                        pend_d = 1'b0;
                        use_q  = 1'b1;
                        start  = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        cmd_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_d;
            if (last_q) ss_n_d = '1;
        end

        if (latch) begin
            slave_d = i_cmd_slave;
            cpol_d  = i_cmd_cpol;
            cpha_d  = i_cmd_cpha;
            lsb_d   = i_cmd_lsb_first;
            div_d   = i_cmd_div;
            bits_d  = bits_c;
            last_d  = i_cmd_last;
            tx_d    = tx_align;
        end

        st_cpol  = use_q ? cpol_q  : i_cmd_cpol;
        st_cpha  = use_q ? cpha_q  : i_cmd_cpha;
        st_lsb   = use_q ? lsb_q   : i_cmd_lsb_first;
        st_div   = use_q ? div_q   : i_cmd_div;
        st_slave = use_q ? slave_q : i_cmd_slave;
        st_tx    = use_q ? tx_q    : tx_align;

        if (start) begin
            state_d     = S_SETUP;
            cnt_d       = st_div;
            sclk_d      = st_cpol;
            ss_n_d      = ss_decode(st_slave);
            bit_idx_d   = '0;
            rx_d        = '0;
            busy_d      = 1'b1;
            cmd_ready_d = 1'b0;
            if (!st_cpha) begin
                mosi_d = bit_out(st_lsb, st_tx);
                tx_d   = shift_out(st_lsb, st_tx);
            end else begin
                tx_d = st_tx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_idx_q   <= '0;
            bits_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            slave_q     <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            last_q      <= 1'b0;
            pend_q      <= 1'b0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ss_n_q      <= '1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_idx_q   <= bit_idx_d;
            bits_q      <= bits_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            slave_q     <= slave_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsb_q       <= lsb_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ss_n_q      <= ss_n_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_sclk      = sclk_q;
    assign o_ss_n      = ss_n_q;
    assign o_mosi      = mosi_q;
    assign o_busy      = busy_q;

endmodule
